// File: rtl/srlatch_hs_array.sv
// srlatch_hs_array
//   Array of NUM_CH independent set/reset latches. Each channel runs a
//   four-phase bundled-data handshake:
//     1. The requester raises s or r.
//     2. After DELAY cycles the latch updates q.
//     3. One cycle after that, ack rises.
//     4. The requester drops s and r.
//     5. DELAY cycles later, ack falls.
//   When s and r are both high at capture, PRIORITY resolves the conflict
//   and conflict pulses for one cycle.
//
// Parameters
//   NUM_CH   : number of channels (>= 1)
//   DELAY    : settle cycles before q update and before ack release (1..255)
//   PRIORITY : 0 = set-dominant, 1 = reset-dominant, 2 = hold q
//   INIT_Q   : reset value of every q bit
//
// Ports
//   clk      : rising-edge clock
//   rst      : synchronous active-high reset
//   s, r     : per-channel set / reset requests
//   q        : latch state (registered)
//   ack      : per-channel handshake acknowledge (registered)
//   busy     : channel FSM not IDLE (registered)
//   conflict : one-cycle pulse when s and r were both captured high
module srlatch_hs_array #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DELAY    = 2,
    parameter int unsigned PRIORITY = 0,
    parameter logic        INIT_Q   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] s,
    input  logic [NUM_CH-1:0] r,
    output logic [NUM_CH-1:0] q,
    output logic [NUM_CH-1:0] ack,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] conflict
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_ACK,
        ST_REL
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(DELAY - 1);

    state_t            r_state [NUM_CH];
    logic [7:0]        r_cnt   [NUM_CH];
    logic [NUM_CH-1:0] r_cs;
    logic [NUM_CH-1:0] r_cr;
    logic [NUM_CH-1:0] r_q;
    logic [NUM_CH-1:0] r_ack;
    logic [NUM_CH-1:0] r_busy;
    logic [NUM_CH-1:0] r_conflict;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_cs       <= '0;
            r_cr       <= '0;
            r_q        <= {NUM_CH{INIT_Q}};
            r_ack      <= '0;
            r_busy     <= '0;
            r_conflict <= '0;
        end else begin
            // conflict is a single-cycle pulse; only the q-update edge sets it
            r_conflict <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (s[i] | r[i]) begin
                            r_cs[i]    <= s[i];
                            r_cr[i]    <= r[i];
                            r_cnt[i]   <= CNT_LOAD;
                            r_busy[i]  <= 1'b1;
                            r_state[i] <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        // s/r are deliberately not looked at here: the
                        // values captured on entry decide the outcome
                        if (r_cnt[i] != '0) begin
                            r_cnt[i] <= r_cnt[i] - 8'd1;
                        end else begin
                            if (r_cs[i] && !r_cr[i]) begin
                                r_q[i] <= 1'b1;
                            end else if (r_cr[i] && !r_cs[i]) begin
                                r_q[i] <= 1'b0;
                            end else if (r_cs[i] && r_cr[i]) begin
                                r_conflict[i] <= 1'b1;
                                if (PRIORITY == 0) begin
                                    r_q[i] <= 1'b1;
                                end else if (PRIORITY == 1) begin
                                    r_q[i] <= 1'b0;
                                end
                            end
                            r_state[i] <= ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        // First ACK cycle raises ack unconditionally so q has
                        // been stable one full cycle before ack is seen.
                        if (!r_ack[i]) begin
                            r_ack[i] <= 1'b1;
                        end else if (!(s[i] | r[i])) begin
                            r_cnt[i]   <= CNT_LOAD;
                            r_state[i] <= ST_REL;
                        end
                    end
                    ST_REL: begin
                        if (r_cnt[i] != '0) begin
                            r_cnt[i] <= r_cnt[i] - 8'd1;
                        end else begin
                            r_ack[i]   <= 1'b0;
                            r_busy[i]  <= 1'b0;
                            r_state[i] <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign q        = r_q;
    assign ack      = r_ack;
    assign busy     = r_busy;
    assign conflict = r_conflict;

endmodule

// File: tb/tb_srlatch_hs_array.sv
// tb_srlatch_hs_array
//   Directed bench for srlatch_hs_array. Three instances share one clock
//   and one reset:
//     u_a : DELAY=2, set-dominant,   INIT_Q=0
//     u_b : DELAY=3, reset-dominant, INIT_Q=0
//     u_c : DELAY=1, hold,           INIT_Q=1
//   Each tick() returns 1 time unit after a rising edge, so the checks that
//   follow observe the state registered at that edge.
module tb_srlatch_hs_array;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sa, ra, sb, rb, sc, rc;
    logic [3:0] qa, acka, busya, cfa;
    logic [3:0] qb, ackb, busyb, cfb;
    logic [3:0] qc, ackc, busyc, cfc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    srlatch_hs_array #(.NUM_CH(4), .DELAY(2), .PRIORITY(0), .INIT_Q(1'b0)) u_a (
        .clk(clk), .rst(rst), .s(sa), .r(ra),
        .q(qa), .ack(acka), .busy(busya), .conflict(cfa)
    );

    srlatch_hs_array #(.NUM_CH(4), .DELAY(3), .PRIORITY(1), .INIT_Q(1'b0)) u_b (
        .clk(clk), .rst(rst), .s(sb), .r(rb),
        .q(qb), .ack(ackb), .busy(busyb), .conflict(cfb)
    );

    srlatch_hs_array #(.NUM_CH(4), .DELAY(1), .PRIORITY(2), .INIT_Q(1'b1)) u_c (
        .clk(clk), .rst(rst), .s(sc), .r(rc),
        .q(qc), .ack(ackc), .busy(busyc), .conflict(cfc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        sa = '0; ra = '0; sb = '0; rb = '0; sc = '0; rc = '0;
        tick();
        tick();
        check("rst_qa", qa, 4'b0000);
        check("rst_acka", acka, 4'b0000);
        check("rst_busya", busya, 4'b0000);
        check("rst_cfa", cfa, 4'b0000);
        check("rst_qc_init1", qc, 4'b1111);

        // 1: set ch0, DELAY=2
        rst = 1'b0;
        sa = 4'b0001;
        tick();                                   // edge 0
        check("t1_busy_e0", busya, 4'b0001);
        check("t1_q_e0", qa, 4'b0000);
        tick();                                   // edge 1
        check("t1_q_e1", qa, 4'b0000);
        tick();                                   // edge 2
        check("t1_q_e2", qa, 4'b0001);
        check("t1_ack_e2", acka, 4'b0000);
        tick();                                   // edge 3
        check("t1_ack_e3", acka, 4'b0001);
        tick();                                   // edge 4
        sa = 4'b0000;
        tick();                                   // edge 5
        tick();                                   // edge 6
        check("t1_ack_e6", acka, 4'b0001);
        tick();                                   // edge 7
        check("t1_ack_e7", acka, 4'b0000);
        check("t1_busy_e7", busya, 4'b0000);

        // 2: set ch1, then reset ch1; ch0 must be untouched
        sa = 4'b0010;
        repeat (3) tick();
        check("t2_set_q", qa, 4'b0011);
        tick();
        check("t2_set_ack", acka, 4'b0010);
        sa = 4'b0000;
        repeat (3) tick();
        check("t2_set_idle", busya, 4'b0000);
        ra = 4'b0010;
        tick();
        check("t2_rst_busy", busya, 4'b0010);
        tick();
        tick();
        check("t2_rst_q", qa, 4'b0001);
        check("t2_rst_ack_early", acka, 4'b0000);
        tick();
        check("t2_rst_ack", acka, 4'b0010);
        ra = 4'b0000;
        repeat (3) tick();
        check("t2_rst_ack_low", acka, 4'b0000);
        check("t2_rst_idle", busya, 4'b0000);

        // 3a: conflict, set-dominant
        sa = 4'b0100;
        ra = 4'b0100;
        tick();
        tick();
        check("t3a_cf_early", cfa, 4'b0000);
        tick();
        check("t3a_q", qa, 4'b0101);
        check("t3a_cf", cfa, 4'b0100);
        tick();
        check("t3a_cf_gone", cfa, 4'b0000);
        check("t3a_ack", acka, 4'b0100);
        sa = 4'b0000;
        ra = 4'b0000;
        repeat (3) tick();
        check("t3a_idle", busya, 4'b0000);

        // 3b: conflict, reset-dominant (DELAY=3), q[2] preset to 1 first
        sb = 4'b0100;
        tick();
        check("t3b_pre_busy", busyb, 4'b0100);
        repeat (2) tick();
        check("t3b_pre_q_early", qb, 4'b0000);
        tick();
        check("t3b_pre_q", qb, 4'b0100);
        tick();
        check("t3b_pre_ack", ackb, 4'b0100);
        sb = 4'b0000;
        repeat (4) tick();
        check("t3b_pre_ack_low", ackb, 4'b0000);
        sb = 4'b0100;
        rb = 4'b0100;
        repeat (3) tick();
        check("t3b_q_early", qb, 4'b0100);
        tick();
        check("t3b_q", qb, 4'b0000);
        check("t3b_cf", cfb, 4'b0100);
        tick();
        check("t3b_cf_gone", cfb, 4'b0000);
        check("t3b_ack", ackb, 4'b0100);
        sb = 4'b0000;
        rb = 4'b0000;
        repeat (4) tick();
        check("t3b_idle", busyb, 4'b0000);

        // 3c: conflict, hold (DELAY=1, q starts at 1)
        sc = 4'b0100;
        rc = 4'b0100;
        tick();
        check("t3c_busy", busyc, 4'b0100);
        tick();
        check("t3c_q_hold", qc, 4'b1111);
        check("t3c_cf", cfc, 4'b0100);
        check("t3c_ack_early", ackc, 4'b0000);
        tick();
        check("t3c_ack", ackc, 4'b0100);
        check("t3c_cf_gone", cfc, 4'b0000);
        sc = 4'b0000;
        rc = 4'b0000;
        tick();
        check("t3c_ack_rel", ackc, 4'b0100);
        tick();
        check("t3c_ack_low", ackc, 4'b0000);
        check("t3c_idle", busyc, 4'b0000);

        // 4: input swaps from s to r one edge into EVAL (DELAY=3)
        sb = 4'b1000;
        tick();
        sb = 4'b0000;
        rb = 4'b1000;
        repeat (2) tick();
        check("t4_q_early", qb, 4'b0000);
        tick();
        check("t4_q_captured", qb, 4'b1000);
        tick();
        check("t4_ack", ackb, 4'b1000);
        tick();
        check("t4_ack_held", ackb, 4'b1000);
        rb = 4'b0000;
        repeat (3) tick();
        check("t4_ack_rel", ackb, 4'b1000);
        tick();
        check("t4_ack_low", ackb, 4'b0000);
        check("t4_idle", busyb, 4'b0000);

        // 5: reset on the edge where q would have updated
        sa = 4'b0001;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t5_q_rst", qa, 4'b0000);
        check("t5_ack_rst", acka, 4'b0000);
        check("t5_busy_rst", busya, 4'b0000);
        check("t5_qc_rst", qc, 4'b1111);
        rst = 1'b0;
        tick();
        check("t5_restart_busy", busya, 4'b0001);
        check("t5_restart_q0", qa, 4'b0000);
        tick();
        tick();
        check("t5_restart_q", qa, 4'b0001);
        tick();
        check("t5_restart_ack", acka, 4'b0001);
        sa = 4'b0000;
        repeat (3) tick();
        check("t5_idle", busya, 4'b0000);

        // 6: all channels at once, mixed s/r, DELAY=2 (u_a) and DELAY=1 (u_c)
        sa = 4'b1010;
        ra = 4'b0101;
        sc = 4'b0011;
        rc = 4'b1100;
        tick();                                   // k
        check("t6_busya", busya, 4'b1111);
        check("t6_busyc", busyc, 4'b1111);
        check("t6_qc_k", qc, 4'b1111);
        tick();                                   // k+1
        check("t6_qc", qc, 4'b0011);
        check("t6_ackc_early", ackc, 4'b0000);
        check("t6_qa_early", qa, 4'b0001);
        tick();                                   // k+2
        check("t6_qa", qa, 4'b1010);
        check("t6_acka_early", acka, 4'b0000);
        check("t6_ackc", ackc, 4'b1111);
        check("t6_cfa", cfa, 4'b0000);
        tick();                                   // k+3
        check("t6_acka", acka, 4'b1111);
        sa = 4'b0000;
        ra = 4'b0000;
        sc = 4'b0000;
        rc = 4'b0000;
        tick();                                   // k+4
        check("t6_ackc_rel", ackc, 4'b1111);
        tick();                                   // k+5
        check("t6_ackc_low", ackc, 4'b0000);
        check("t6_acka_rel", acka, 4'b1111);
        tick();                                   // k+6
        check("t6_acka_low", acka, 4'b0000);
        check("t6_busya_idle", busya, 4'b0000);
        check("t6_busyc_idle", busyc, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
